// File: rtl/execute_issue_stage.sv
// ID/EX register and operand issue: holds one decoded instruction, forwards MEM/WB into ALU operands.
// Latency: one cycle from decode accept to ex_valid; back-to-back issue with no bubble.
// Backpressure: valid/ready both sides; a load-use hazard or ex_ready low holds the entry and deasserts dec_ready.
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

package execute_issue_pkg;
  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    SLL  = 4'd5,
    SRL  = 4'd6,
    SRA  = 4'd7,
    SLT  = 4'd8,
    SLTU = 4'd9
  } aluOperation;
endpackage

module execute_issue_stage
  import execute_issue_pkg::*;
#(
  parameter int DATA_WIDTH = `BIT_COUNT,
  parameter int REG_AW     = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  aluOperation           dec_alu_op,
  input  logic [REG_AW-1:0]     dec_rs1,
  input  logic [REG_AW-1:0]     dec_rs2,
  input  logic [DATA_WIDTH-1:0] dec_rs1_data,
  input  logic [DATA_WIDTH-1:0] dec_rs2_data,
  input  logic [DATA_WIDTH-1:0] dec_imm,
  input  logic [DATA_WIDTH-1:0] dec_pc,
  input  logic                  dec_use_imm,
  input  logic                  dec_use_pc,
  input  logic [REG_AW-1:0]     dec_rd,
  input  logic                  dec_reg_write,
  input  logic                  mem_fwd_valid,
  input  logic                  mem_fwd_is_load,
  input  logic [REG_AW-1:0]     mem_fwd_rd,
  input  logic [DATA_WIDTH-1:0] mem_fwd_data,
  input  logic                  wb_fwd_valid,
  input  logic [REG_AW-1:0]     wb_fwd_rd,
  input  logic [DATA_WIDTH-1:0] wb_fwd_data,
  input  logic                  ex_ready,
  output logic                  ex_valid,
  output aluOperation           ALUOp,
  output logic [DATA_WIDTH-1:0] ALUOpA,
  output logic [DATA_WIDTH-1:0] ALUOpB,
  output logic [REG_AW-1:0]     ex_rd,
  output logic                  ex_reg_write
);

  typedef struct packed {
    aluOperation           alu_op;
    logic [REG_AW-1:0]     rs1;
    logic [REG_AW-1:0]     rs2;
    logic [REG_AW-1:0]     rd;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] pc;
    logic                  use_imm;
    logic                  use_pc;
    logic                  reg_write;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, READY, HAZARD} state_t;

  state_t state_q, state_d, state_view;
  entry_t entry_q, entry_d;
  logic   full, hazard, fire, accept;
  logic   wb_hit1, wb_hit2, wb_cap1, wb_cap2;
  logic   mem_hit1, mem_hit2;
  logic [DATA_WIDTH-1:0] rs1_fwd, rs2_fwd;

  // Registered state only tracks occupancy; the hazard overlay is recomputed every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    full       = (state_q != EMPTY);
    hazard     = full & mem_fwd_valid & mem_fwd_is_load & (mem_fwd_rd != '0) &
                 (((mem_fwd_rd == entry_q.rs1) & ~entry_q.use_pc) |
                  ((mem_fwd_rd == entry_q.rs2) & ~entry_q.use_imm));
    state_view = !full ? EMPTY : (hazard ? HAZARD : READY);
    ex_valid   = (state_view == READY);
    fire       = ex_valid & ex_ready;
    dec_ready  = ~full | fire;
    accept     = dec_valid & dec_ready & ~flush;
    if (flush)       state_d = EMPTY;
    else if (accept) state_d = READY;
    else if (fire)   state_d = EMPTY;
  end

  // Capture folds in a same-cycle register-file write so the entry never holds stale data.
  assign wb_cap1 = wb_fwd_valid & (wb_fwd_rd == dec_rs1) & (dec_rs1 != '0);
  assign wb_cap2 = wb_fwd_valid & (wb_fwd_rd == dec_rs2) & (dec_rs2 != '0);

  always_comb begin
    entry_d           = '0;
    entry_d.alu_op    = dec_alu_op;
    entry_d.rs1       = dec_rs1;
    entry_d.rs2       = dec_rs2;
    entry_d.rd        = dec_rd;
    entry_d.rs1_data  = wb_cap1 ? wb_fwd_data : dec_rs1_data;
    entry_d.rs2_data  = wb_cap2 ? wb_fwd_data : dec_rs2_data;
    entry_d.imm       = dec_imm;
    entry_d.pc        = dec_pc;
    entry_d.use_imm   = dec_use_imm;
    entry_d.use_pc    = dec_use_pc;
    entry_d.reg_write = dec_reg_write;
  end

  assign wb_hit1  = wb_fwd_valid & (wb_fwd_rd == entry_q.rs1) & (entry_q.rs1 != '0);
  assign wb_hit2  = wb_fwd_valid & (wb_fwd_rd == entry_q.rs2) & (entry_q.rs2 != '0);
  assign mem_hit1 = mem_fwd_valid & ~mem_fwd_is_load & (mem_fwd_rd == entry_q.rs1) & (entry_q.rs1 != '0);
  assign mem_hit2 = mem_fwd_valid & ~mem_fwd_is_load & (mem_fwd_rd == entry_q.rs2) & (entry_q.rs2 != '0);

  // While held, WB results are absorbed so a producer retiring mid-stall is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry_q <= '0;
    end else if (accept) begin
      entry_q <= entry_d;
    end else if (full && !fire) begin
      if (wb_hit1) entry_q.rs1_data <= wb_fwd_data;
      if (wb_hit2) entry_q.rs2_data <= wb_fwd_data;
    end
  end

  assign rs1_fwd = (entry_q.rs1 == '0) ? '0 :
                   mem_hit1 ? mem_fwd_data :
                   wb_hit1  ? wb_fwd_data  : entry_q.rs1_data;
  assign rs2_fwd = (entry_q.rs2 == '0) ? '0 :
                   mem_hit2 ? mem_fwd_data :
                   wb_hit2  ? wb_fwd_data  : entry_q.rs2_data;

  assign ALUOp        = entry_q.alu_op;
  assign ALUOpA       = entry_q.use_pc  ? entry_q.pc  : rs1_fwd;
  assign ALUOpB       = entry_q.use_imm ? entry_q.imm : rs2_fwd;
  assign ex_rd        = entry_q.rd;
  assign ex_reg_write = entry_q.reg_write;

endmodule

// File: tb/tb_execute_issue_stage.sv
// Bench for execute_issue_stage: directed vector table, hand-written corner sequences,
// and random traffic checked against a register-file level reference model.
module tb_execute_issue_stage;
  import execute_issue_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset_n, flush, dec_valid, dec_ready;
  aluOperation   dec_alu_op, ALUOp;
  logic [AW-1:0] dec_rs1, dec_rs2, dec_rd, mem_fwd_rd, wb_fwd_rd, ex_rd;
  logic [DW-1:0] dec_rs1_data, dec_rs2_data, dec_imm, dec_pc, mem_fwd_data, wb_fwd_data;
  logic [DW-1:0] ALUOpA, ALUOpB;
  logic          dec_use_imm, dec_use_pc, dec_reg_write, mem_fwd_valid, mem_fwd_is_load;
  logic          wb_fwd_valid, ex_ready, ex_valid, ex_reg_write;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_issue_stage #(.DATA_WIDTH(DW), .REG_AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_alu_op(dec_alu_op),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data),
    .dec_imm(dec_imm), .dec_pc(dec_pc), .dec_use_imm(dec_use_imm), .dec_use_pc(dec_use_pc),
    .dec_rd(dec_rd), .dec_reg_write(dec_reg_write),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_is_load(mem_fwd_is_load),
    .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ALUOp(ALUOp),
    .ALUOpA(ALUOpA), .ALUOpB(ALUOpB), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    flush = 0; dec_valid = 0; dec_alu_op = ADD; dec_rs1 = 0; dec_rs2 = 0;
    dec_rs1_data = 0; dec_rs2_data = 0; dec_imm = 0; dec_pc = 0;
    dec_use_imm = 0; dec_use_pc = 0; dec_rd = 0; dec_reg_write = 0;
    mem_fwd_valid = 0; mem_fwd_is_load = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_valid = 0; wb_fwd_rd = 0; wb_fwd_data = 0; ex_ready = 0;
  endtask

  task automatic offer(input aluOperation op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [DW-1:0] d1, input logic [DW-1:0] d2, input logic [AW-1:0] rd);
    dec_valid = 1; dec_alu_op = op; dec_rs1 = rs1; dec_rs2 = rs2;
    dec_rs1_data = d1; dec_rs2_data = d2; dec_rd = rd; dec_reg_write = 1;
  endtask

  typedef struct {
    logic [AW-1:0] rs1, rs2;
    logic [DW-1:0] d1, d2, imm, pc;
    logic          ui, up;
    logic          mv, ml;
    logic [AW-1:0] mrd;
    logic [DW-1:0] md;
    logic          wv;
    logic [AW-1:0] wrd;
    logic [DW-1:0] wd;
    logic          ev, ec;
    logic [DW-1:0] ea, eb;
  } vec_t;

  vec_t vecs[11];

  typedef struct {
    aluOperation   op;
    logic [AW-1:0] rs1, rs2, rd;
    logic [DW-1:0] imm, pc;
    logic          ui, up, rw;
  } minst_t;

  logic [DW-1:0] rf[32];
  minst_t        mi;
  logic          m_full;

  function automatic logic [DW-1:0] ref_val(input logic [AW-1:0] r);
    if (r == 0) return '0;
    if (mem_fwd_valid && !mem_fwd_is_load && mem_fwd_rd == r) return mem_fwd_data;
    if (wb_fwd_valid && wb_fwd_rd == r) return wb_fwd_data;
    return rf[r];
  endfunction

  initial begin
    //           rs1 rs2 d1     d2     imm       pc       ui up mv ml mrd md      wv wrd wd      ev ec ea       eb
    vecs[0]  = '{5, 1, 32'h1,  32'h2,  0,        0,       0, 0, 1, 0, 5, 32'h10, 0, 0, 0,      1, 1, 32'h10, 32'h2};
    vecs[1]  = '{7, 2, 32'h3,  32'h4,  0,        0,       0, 0, 1, 1, 7, 32'h99, 0, 0, 0,      0, 0, 0,      0};
    vecs[2]  = '{1, 3, 32'h11, 32'h22, 0,        0,       0, 0, 0, 0, 0, 0,      1, 3, 32'h55, 1, 1, 32'h11, 32'h55};
    vecs[3]  = '{0, 2, 32'h77, 32'h5,  0,        0,       0, 0, 1, 0, 0, 32'hFF, 0, 0, 0,      1, 1, 0,      32'h5};
    vecs[4]  = '{0, 2, 32'h0,  32'h5,  0,        32'h100, 0, 1, 1, 0, 0, 32'hFF, 0, 0, 0,      1, 1, 32'h100, 32'h5};
    vecs[5]  = '{1, 7, 32'h3,  32'h4,  32'h1234, 0,       1, 0, 1, 1, 7, 32'h99, 0, 0, 0,      1, 1, 32'h3,  32'h1234};
    vecs[6]  = '{4, 2, 32'h1,  32'h2,  0,        0,       0, 0, 1, 0, 4, 32'hAA, 1, 4, 32'hBB, 1, 1, 32'hAA, 32'h2};
    vecs[7]  = '{1, 2, 32'h1,  32'h2,  0,        0,       0, 0, 1, 1, 2, 32'h0,  0, 0, 0,      0, 0, 0,      0};
    vecs[8]  = '{0, 3, 32'h0,  32'h3,  0,        0,       0, 0, 1, 1, 0, 32'h9,  0, 0, 0,      1, 1, 0,      32'h3};
    vecs[9]  = '{0, 6, 32'h9,  32'h6,  0,        0,       0, 0, 0, 0, 0, 0,      1, 0, 32'hCC, 1, 1, 0,      32'h6};
    vecs[10] = '{7, 1, 32'h0,  32'h8,  0,        32'h200, 0, 1, 1, 1, 7, 32'h0,  0, 0, 0,      1, 1, 32'h200, 32'h8};

    idle();
    reset_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_dec_ready", dec_ready, 1);
    chk("rst_aluop", 64'(ALUOp), 64'(ADD));
    chk("rst_opa", ALUOpA, 0);
    chk("rst_opb", ALUOpB, 0);
    chk("rst_rd_rw", {ex_rd, ex_reg_write}, 0);
    reset_n = 1;

    // Table: load one entry while stalled, then apply MEM/WB and inspect the issue outputs.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      idle();
      offer(SUB, vecs[i].rs1, vecs[i].rs2, vecs[i].d1, vecs[i].d2, 5'd9);
      dec_imm = vecs[i].imm; dec_pc = vecs[i].pc;
      dec_use_imm = vecs[i].ui; dec_use_pc = vecs[i].up;
      @(negedge clk);
      dec_valid = 0;
      mem_fwd_valid = vecs[i].mv; mem_fwd_is_load = vecs[i].ml;
      mem_fwd_rd = vecs[i].mrd; mem_fwd_data = vecs[i].md;
      wb_fwd_valid = vecs[i].wv; wb_fwd_rd = vecs[i].wrd; wb_fwd_data = vecs[i].wd;
      #1;
      chk($sformatf("vec%0d_valid", i), ex_valid, vecs[i].ev);
      if (vecs[i].ec) begin
        chk($sformatf("vec%0d_opa", i), ALUOpA, vecs[i].ea);
        chk($sformatf("vec%0d_opb", i), ALUOpB, vecs[i].eb);
      end
      flush = 1;
      @(negedge clk);
      idle();
    end

    // Load-use: one stall cycle, then the WB load data reaches operand A.
    @(negedge clk);
    idle(); ex_ready = 1;
    offer(ADD, 5'd7, 5'd2, 32'h1, 32'h2, 5'd8);
    #1 chk("lu_accept_ready", dec_ready, 1);
    @(negedge clk);
    dec_valid = 0;
    mem_fwd_valid = 1; mem_fwd_is_load = 1; mem_fwd_rd = 7; mem_fwd_data = 32'h1234;
    #1;
    chk("lu_stall_valid", ex_valid, 0);
    chk("lu_stall_ready", dec_ready, 0);
    @(negedge clk);
    mem_fwd_valid = 0; mem_fwd_is_load = 0;
    wb_fwd_valid = 1; wb_fwd_rd = 7; wb_fwd_data = 32'hDEAD;
    #1;
    chk("lu_release_valid", ex_valid, 1);
    chk("lu_opa", ALUOpA, 32'hDEAD);
    chk("lu_opb", ALUOpB, 32'h2);
    chk("lu_rd", ex_rd, 8);
    @(negedge clk);
    wb_fwd_valid = 0;
    #1 chk("lu_drained", ex_valid, 0);

    // Long stall: WB writes x3 during the stall and the held entry keeps it.
    @(negedge clk);
    idle();
    offer(OR, 5'd1, 5'd3, 32'h5, 32'h11, 5'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dec_valid = 0;
      wb_fwd_valid = (i == 1); wb_fwd_rd = 3; wb_fwd_data = 32'h55;
      #1 chk($sformatf("ls_hold%0d", i), ex_valid, 1);
    end
    @(negedge clk);
    wb_fwd_valid = 0; ex_ready = 1;
    #1;
    chk("ls_opb", ALUOpB, 32'h55);
    chk("ls_opa", ALUOpA, 32'h5);
    chk("ls_op", 64'(ALUOp), 64'(OR));
    @(negedge clk);
    #1 chk("ls_drained", ex_valid, 0);

    // Flush while full with a new offer: the held and the incoming instruction both vanish.
    @(negedge clk);
    idle();
    offer(XOR, 5'd1, 5'd2, 32'h1, 32'h2, 5'd3);
    @(negedge clk);
    offer(AND, 5'd4, 5'd5, 32'h4, 32'h5, 5'd6);
    flush = 1;
    #1 chk("fl_same_cycle_valid", ex_valid, 1);
    @(negedge clk);
    idle(); ex_ready = 1;
    #1;
    chk("fl_next_valid", ex_valid, 0);
    chk("fl_next_ready", dec_ready, 1);
    @(negedge clk);
    #1 chk("fl_dropped", ex_valid, 0);

    // Reset mid-stall.
    @(negedge clk);
    idle();
    offer(SUB, 5'd0, 5'd2, 32'h0, 32'h9, 5'd5);
    dec_use_pc = 1; dec_pc = 32'h300;
    @(negedge clk);
    dec_valid = 0;
    #1 chk("rs_full_valid", ex_valid, 1);
    reset_n = 0;
    #1;
    chk("rs_valid", ex_valid, 0);
    chk("rs_opa", ALUOpA, 0);
    chk("rs_opb", ALUOpB, 0);
    chk("rs_ready", dec_ready, 1);
    chk("rs_aluop", 64'(ALUOp), 64'(ADD));
    @(negedge clk);
    reset_n = 1;
    #1 chk("rs_ready_after", dec_ready, 1);

    // Random traffic against the register-file model.
    for (int r = 0; r < 32; r++) rf[r] = '0;
    m_full = 0;
    mi = '{ADD, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic          e_valid, e_ready, e_fire, e_acc, e_haz;
      @(negedge clk);
      dec_valid = ($urandom_range(0, 3) != 0);
      dec_alu_op = aluOperation'($urandom_range(0, 9));
      dec_rs1 = AW'($urandom_range(0, 7)); dec_rs2 = AW'($urandom_range(0, 7));
      dec_rs1_data = rf[dec_rs1]; dec_rs2_data = rf[dec_rs2];
      dec_imm = $urandom; dec_pc = $urandom;
      dec_use_imm = ($urandom_range(0, 3) == 0); dec_use_pc = ($urandom_range(0, 3) == 0);
      dec_rd = AW'($urandom_range(0, 7)); dec_reg_write = 1'($urandom_range(0, 1));
      mem_fwd_valid = 1'($urandom_range(0, 1)); mem_fwd_is_load = ($urandom_range(0, 2) == 0);
      mem_fwd_rd = AW'($urandom_range(0, 7)); mem_fwd_data = $urandom;
      wb_fwd_valid = 1'($urandom_range(0, 1));
      wb_fwd_rd = AW'($urandom_range(0, 7)); wb_fwd_data = $urandom;
      ex_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      #1;
      e_haz = m_full && mem_fwd_valid && mem_fwd_is_load && mem_fwd_rd != 0 &&
              ((!mi.up && mem_fwd_rd == mi.rs1) || (!mi.ui && mem_fwd_rd == mi.rs2));
      e_valid = m_full && !e_haz;
      e_fire  = e_valid && ex_ready;
      e_ready = !m_full || e_fire;
      e_acc   = dec_valid && e_ready && !flush;
      chk("rnd_valid", ex_valid, e_valid);
      chk("rnd_dec_ready", dec_ready, e_ready);
      if (e_valid) begin
        chk("rnd_op", 64'(ALUOp), 64'(mi.op));
        chk("rnd_opa", ALUOpA, mi.up ? mi.pc : ref_val(mi.rs1));
        chk("rnd_opb", ALUOpB, mi.ui ? mi.imm : ref_val(mi.rs2));
        chk("rnd_rd", {ex_rd, ex_reg_write}, {mi.rd, mi.rw});
      end
      if (flush) m_full = 0;
      else if (e_acc) begin
        m_full = 1;
        mi = '{dec_alu_op, dec_rs1, dec_rs2, dec_rd, dec_imm, dec_pc, dec_use_imm, dec_use_pc, dec_reg_write};
      end else if (e_fire) m_full = 0;
      if (wb_fwd_valid && wb_fwd_rd != 0) rf[wb_fwd_rd] = wb_fwd_data;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
